decimal_entry: RTL and testbench
================================

# decimal_entry

Digit-entry path for the calculator: collects decimal digits and a sign from the keypad/switch front end, echoes the pending entry as BCD digits plus a sign flag, and on `enter` converts the sign-magnitude decimal entry into a 32-bit two's-complement operand. It is the input-side counterpart of the result display chain, which goes two's complement → sign-magnitude → BCD → seven-segment. Its BCD echo outputs feed the same `Display` decoders that result digits use.

## Interface
- `NUM_DIGITS`, 7: maximum digits per entry; matches the seven numeric displays.
- `WIDTH`, 32: width of the converted operand.
- `clk`  in  1  single clock; everything is rising-edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `digit_valid`  in  1  one-cycle strobe qualifying `digit`.
- `digit`  in  4  BCD digit, 0–9; 10–15 are ignored.
- `sign_toggle`  in  1  one-cycle strobe that flips the entry sign.
- `clear`  in  1  one-cycle strobe that discards the entry.
- `enter`  in  1  one-cycle strobe that starts conversion.
- `d0`..`d6`  out  4 each  echoed entry digits; `d0` is least significant; unused positions read 0.
- `sign`  out  1  1 = negative entry; drives the minus display.
- `count`  out  3  number of digits held, 0..7.
- `full`  out  1  high when `count == NUM_DIGITS`.
- `busy`  out  1  high while conversion runs.
- `value`  out  WIDTH  converted two's-complement operand; held until the next conversion.
- `value_valid`  out  1  one-cycle pulse marking a new `value`.

## Operation
- Reset: all outputs are 0; state ENTRY; digit buffer, `sign`, `count` and the accumulator are cleared.
- ENTRY state accepts at most one action per cycle. Priority is `clear` > `enter` > `sign_toggle` > `digit_valid`; lower-priority strobes in the same cycle are dropped.
  - `clear`: buffer, `sign` and `count` go to 0; `value` is unchanged.
  - `digit_valid` with `digit` ≤ 9 and not `full`: the buffer shifts left one position (`d6`←`d5` … `d1`←`d0`, `d0`←`digit`) and `count` increments.
  - Digit ignored when `full`, when `digit` > 9, or when `digit == 0` and `count == 0` (leading zeros are not stored).
  - `sign_toggle`: `sign` inverts. It is allowed with `count == 0`.
  - `enter`: go to CONVERT; accumulator ← 0; digit index ← `count`−1. With `count == 0`, go directly to DONE with magnitude 0.
- CONVERT: each cycle `acc ← acc*10 + buffer[index]`, walking from the most significant held digit down to `d0`, then the index decrements. `acc*10` is implemented as `(acc<<3)+(acc<<1)`.
  - Maximum magnitude is 9 999 999, which is below 2^24, so no overflow is possible.
  - After the `d0` step, go to DONE.
- DONE, one cycle:
  - `value` ← `sign` ? −acc : acc, with −0 producing 0.
  - `value_valid` = 1.
  - Buffer, `sign` and `count` are cleared, ready for the next operand.
  - Next state is ENTRY.
- `busy` = 1 in CONVERT and DONE. All strobes are ignored while busy, including `clear`.
- Reset mid-conversion: the conversion is abandoned, `value_valid` does not pulse, and `value` returns to 0.

## Timing
- All outputs are registered.
- Digit echo: a `digit_valid` sampled at edge t appears on `d0` and `count` after edge t.
- Conversion latency: `enter` sampled at edge t with n digits (n ≥ 1) gives CONVERT for edges t+1..t+n and `value_valid` high for the cycle following edge t+n+1. With n = 0, the valid cycle follows edge t+1.
- `value_valid` is high for exactly one cycle per `enter`.
- Back-to-back: a new digit is accepted at the first edge after `value_valid`.

## Structure
- Shared package `calc_pkg` holds the state enum (ENTRY, CONVERT, DONE), `NUM_DIGITS`, and the constant `BCD_MAX = 4'd9`. The output-side BCD logic uses the same digit constants.
- One natural sub-module, `bcd_mac10`: a combinational `acc*10 + digit` over `WIDTH` bits.
- The top level holds the FSM, digit buffer, index counter, and the negate/output registers.

## Test plan
- Reset, then digits 1,2,3, then `enter`.
  - After each digit: `d2 d1 d0` = 1 2 3 and `count` = 3.
  - `value` = 123 (0x0000007B) with a single `value_valid` pulse 5 cycles after `enter`.
  - Then `count` = 0 and `busy` is low.
- Digits 4,5, then `sign_toggle`, then `enter` → `value` = 0xFFFFFFD3 (−45) and `sign` = 1 before the pulse.
- Nine digits 9 → `full` = 1 after the seventh; the eighth and ninth are ignored; `enter` → `value` = 9 999 999 (0x0098967F), 7 CONVERT cycles.
- Leading zeros and odd strobes:
  - Digits 0,0,7 → `count` = 1 and `d0` = 7.
  - Digit 12 → ignored.
  - `sign_toggle` then `enter` with an empty buffer → `value` = 0, not negative.
- Same-cycle `clear` + `enter` → entry cleared, no `value_valid`. Same-cycle `digit_valid` + `sign_toggle` → only the sign flips.
- Mid-conversion events:
  - `clear` and digit strobes during CONVERT → ignored; the result is unaffected.
  - `rst_n` low during CONVERT → all outputs 0 and no `value_valid` pulse.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared calculator constants and the digit-entry state type.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int         NUM_DIGITS = 7;
    localparam logic [3:0] BCD_MAX    = 4'd9;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_mac10.sv
`default_nettype none
// ============================================================================
// Module      : bcd_mac10
// Description : Combinational multiply-by-ten and add one BCD digit.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_mac10 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [3:0]       digit_i,
    output logic [WIDTH-1:0] result_o
);

    // x*10 built from two shifts so no multiplier is inferred
    assign result_o = (acc_i << 3) + (acc_i << 1) + {{(WIDTH-4){1'b0}}, digit_i};

endmodule
`default_nettype wire

// File: rtl/decimal_entry.sv
`default_nettype none
// ============================================================================
// Module      : decimal_entry
// Description : Keypad digit/sign entry with BCD echo and serial conversion
//               of the sign-magnitude entry to a two's-complement operand.
// Revision    : 1.0 - initial release
// ============================================================================
module decimal_entry #(
    parameter int NUM_DIGITS = calc_pkg::NUM_DIGITS,
    parameter int WIDTH      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             digit_valid,
    input  logic [3:0]       digit,
    input  logic             sign_toggle,
    input  logic             clear,
    input  logic             enter,
    output logic [3:0]       d0,
    output logic [3:0]       d1,
    output logic [3:0]       d2,
    output logic [3:0]       d3,
    output logic [3:0]       d4,
    output logic [3:0]       d5,
    output logic [3:0]       d6,
    output logic             sign,
    output logic [2:0]       count,
    output logic             full,
    output logic             busy,
    output logic [WIDTH-1:0] value,
    output logic             value_valid
);

    import calc_pkg::*;

    localparam int         BW      = NUM_DIGITS * 4;
    localparam logic [2:0] MAX_CNT = 3'(NUM_DIGITS);

    state_t           state_q, state_d;
    logic [BW-1:0]    buf_q, buf_d;
    logic             sign_q, sign_d;
    logic [2:0]       count_q, count_d;
    logic [2:0]       idx_q, idx_d;
    logic             full_q, full_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] mac_res;
    logic [3:0]       cur_digit;
    logic             digit_ok;

    assign cur_digit = buf_q[idx_q*4 +: 4];

    // Leading zeros are dropped so the count reflects significant digits only
    assign digit_ok = digit_valid && (digit <= BCD_MAX) && !full_q
                      && !((digit == 4'd0) && (count_q == 3'd0));

    bcd_mac10 #(
        .WIDTH (WIDTH)
    ) u_mac (
        .acc_i    (acc_q),
        .digit_i  (cur_digit),
        .result_o (mac_res)
    );

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        sign_d  = sign_q;
        count_d = count_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        value_d = value_q;
        valid_d = 1'b0;
        case (state_q)
            ENTRY: begin
                if (clear) begin
                    buf_d   = '0;
                    sign_d  = 1'b0;
                    count_d = 3'd0;
                end else if (enter) begin
                    acc_d = '0;
                    if (count_q == 3'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = CONVERT;
                        idx_d   = count_q - 3'd1;
                    end
                end else if (sign_toggle) begin
                    sign_d = ~sign_q;
                end else if (digit_ok) begin
                    buf_d   = {buf_q[BW-5:0], digit};
                    count_d = count_q + 3'd1;
                end
            end
            CONVERT: begin
                acc_d = mac_res;
                if (idx_q == 3'd0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 3'd1;
                end
            end
            DONE: begin
                value_d = sign_q ? -acc_q : acc_q;
                valid_d = 1'b1;
                buf_d   = '0;
                sign_d  = 1'b0;
                count_d = 3'd0;
                state_d = ENTRY;
            end
            default: state_d = ENTRY;
        endcase
        full_d = (count_d == MAX_CNT);
        busy_d = (state_d != ENTRY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ENTRY;
            buf_q   <= '0;
            sign_q  <= 1'b0;
            count_q <= 3'd0;
            idx_q   <= 3'd0;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
            acc_q   <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            sign_q  <= sign_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            full_q  <= full_d;
            busy_q  <= busy_d;
            acc_q   <= acc_d;
            value_q <= value_d;
            valid_q <= valid_d;
        end
    end

    assign d0          = buf_q[3:0];
    assign d1          = buf_q[7:4];
    assign d2          = buf_q[11:8];
    assign d3          = buf_q[15:12];
    assign d4          = buf_q[19:16];
    assign d5          = buf_q[23:20];
    assign d6          = buf_q[27:24];
    assign sign        = sign_q;
    assign count       = count_q;
    assign full        = full_q;
    assign busy        = busy_q;
    assign value       = value_q;
    assign value_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_decimal_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_decimal_entry
// Description : Self-checking bench for decimal_entry against a digit-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decimal_entry;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic        sign_toggle = 1'b0;
    logic        clear = 1'b0;
    logic        enter = 1'b0;
    logic [3:0]  d0, d1, d2, d3, d4, d5, d6;
    logic        sign, full, busy, value_valid;
    logic [2:0]  count;
    logic [31:0] value;
    logic [3:0]  dobs [7];

    int          total = 0;
    int          bad = 0;
    int          q[$];
    bit          msign = 1'b0;
    logic [31:0] mval = 32'd0;

    decimal_entry dut (
        .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit(digit),
        .sign_toggle(sign_toggle), .clear(clear), .enter(enter),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6),
        .sign(sign), .count(count), .full(full), .busy(busy),
        .value(value), .value_valid(value_valid)
    );

    always #5 clk = ~clk;

    assign dobs[0] = d0;
    assign dobs[1] = d1;
    assign dobs[2] = d2;
    assign dobs[3] = d3;
    assign dobs[4] = d4;
    assign dobs[5] = d5;
    assign dobs[6] = d6;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mdig(input int k);
        return (k < q.size()) ? q[q.size()-1-k] : 0;
    endfunction

    // Compare every visible output against the model while idle in entry
    task automatic chk_idle(input string tag);
        for (int k = 0; k < 7; k++) chk($sformatf("%s_d%0d", tag, k), 32'(dobs[k]), 32'(mdig(k)));
        chk({tag, "_count"}, 32'(count), 32'(q.size()));
        chk({tag, "_full"},  32'(full),  32'(q.size() == 7));
        chk({tag, "_sign"},  32'(sign),  32'(msign));
        chk({tag, "_busy"},  32'(busy),  32'd0);
        chk({tag, "_vv"},    32'(value_valid), 32'd0);
        chk({tag, "_value"}, value, mval);
    endtask

    task automatic step(input bit dv, input int d, input bit st, input bit clr, input string tag);
        digit_valid = dv; digit = 4'(d); sign_toggle = st; clear = clr;
        @(posedge clk); #1;
        digit_valid = 1'b0; sign_toggle = 1'b0; clear = 1'b0;
        if (clr) begin
            q.delete(); msign = 1'b0;
        end else if (st) begin
            msign = ~msign;
        end else if (dv && d <= 9 && q.size() < 7 && !(d == 0 && q.size() == 0)) begin
            q.push_back(d);
        end
        chk_idle(tag);
    endtask

    task automatic do_enter(input bit noise, input string tag);
        longint mag = 0;
        int     n = q.size();
        int     lat = 0;
        foreach (q[i]) mag = mag * 10 + q[i];
        enter = 1'b1;
        if (noise) begin
            sign_toggle = 1'($urandom); digit_valid = 1'b1; digit = 4'($urandom_range(0, 9));
        end
        @(posedge clk); #1;
        enter = 1'b0; sign_toggle = 1'b0; digit_valid = 1'b0;
        while (!value_valid && lat < 20) begin
            chk({tag, "_busy_run"}, 32'(busy), 32'd1);
            chk({tag, "_sign_run"}, 32'(sign), 32'(msign));
            if (noise) begin
                clear = 1'($urandom); digit_valid = 1'b1; digit = 4'($urandom_range(0, 15));
                sign_toggle = 1'($urandom); enter = 1'($urandom);
            end
            @(posedge clk); #1;
            clear = 1'b0; digit_valid = 1'b0; sign_toggle = 1'b0; enter = 1'b0;
            lat++;
        end
        mval = msign ? 32'(-mag) : 32'(mag);
        q.delete(); msign = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(n + 1));
        chk({tag, "_vv_pulse"}, 32'(value_valid), 32'd1);
        chk({tag, "_value"}, value, mval);
        chk({tag, "_cnt_after"}, 32'(count), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_sign_after"}, 32'(sign), 32'd0);
        step(1'b0, 0, 1'b0, 1'b0, {tag, "_post"});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        rst_n = 1'b1;

        step(1'b1, 1, 1'b0, 1'b0, "dig1");
        step(1'b1, 2, 1'b0, 1'b0, "dig2");
        step(1'b1, 3, 1'b0, 1'b0, "dig3");
        do_enter(1'b0, "e123");
        chk("const123", value, 32'h0000007B);

        step(1'b1, 4, 1'b0, 1'b0, "dig4");
        step(1'b1, 5, 1'b0, 1'b0, "dig5");
        step(1'b0, 0, 1'b1, 1'b0, "neg");
        do_enter(1'b0, "em45");
        chk("constm45", value, 32'hFFFFFFD3);

        for (int i = 0; i < 9; i++) step(1'b1, 9, 1'b0, 1'b0, "nine");
        do_enter(1'b0, "efull");
        chk("constmax", value, 32'h0098967F);

        step(1'b1, 0, 1'b0, 1'b0, "lz0");
        step(1'b1, 0, 1'b0, 1'b0, "lz1");
        step(1'b1, 7, 1'b0, 1'b0, "lz7");
        step(1'b1, 12, 1'b0, 1'b0, "bad12");
        step(1'b0, 0, 1'b0, 1'b1, "clr");
        step(1'b0, 0, 1'b1, 1'b0, "negempty");
        do_enter(1'b0, "ezero");
        chk("constzero", value, 32'h00000000);

        step(1'b1, 6, 1'b0, 1'b0, "ce6");
        step(1'b1, 8, 1'b0, 1'b0, "ce8");
        clear = 1'b1; enter = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; enter = 1'b0;
        q.delete(); msign = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b0, 1'b0, "clr_ent");
        step(1'b1, 5, 1'b1, 1'b0, "dv_st");

        step(1'b1, 3, 1'b0, 1'b0, "nz3");
        step(1'b1, 1, 1'b0, 1'b0, "nz1");
        step(1'b1, 4, 1'b0, 1'b0, "nz4");
        do_enter(1'b1, "enoise");

        for (int i = 0; i < 5; i++) step(1'b1, i + 2, 1'b0, 1'b0, "pre_rst");
        enter = 1'b1;
        @(posedge clk); #1;
        enter = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete(); msign = 1'b0; mval = 32'd0;
        chk_idle("midrst");
        for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b0, 1'b0, "after_rst");

        for (int i = 0; i < 300; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 5)       step(1'b0, 0, 1'($urandom), 1'b1, "rnd_clr");
            else if (r < 12) do_enter(1'($urandom), "rnd_ent");
            else if (r < 20) step(1'($urandom), $urandom_range(0, 15), 1'b1, 1'b0, "rnd_sgn");
            else             step(1'b1, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15),
                                  1'b0, 1'b0, "rnd_dig");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
